// File: rtl/fir_coeff_loader_pkg.sv
// Shared constants and FSM state type for the FIR coefficient loader.
// The CHECK state only exists when FIR_COEFF_CKSUM_EN is defined.
package fir_coeff_loader_pkg;

    localparam int NTAPS           = 8;
    localparam int COEFF_W         = 16;
    localparam int COEFF_FRAC_BITS = 13;
    localparam int IDX_W           = $clog2(NTAPS);

    // Unity gain in the 2^13-scaled coefficient format.
    localparam logic [COEFF_W-1:0] UNITY_COEFF = COEFF_W'(1 << COEFF_FRAC_BITS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
`ifdef FIR_COEFF_CKSUM_EN
        CHECK  = 2'd2,
`endif
        COMMIT = 2'd3
    } loader_state_e;

endpackage

// File: rtl/fir_coeff_loader.sv
// Double-buffered loader for the 8-tap FIR coefficient bank, fed by a valid/ready word stream.
// Define FIR_COEFF_CKSUM_EN to require a trailing wrap-around checksum word before commit.
module fir_coeff_loader
    import fir_coeff_loader_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               LOAD_START,
    input  logic [COEFF_W-1:0] WORD_IN,
    input  logic               WORD_VALID,
    output logic               WORD_READY,
    input  logic               ENABLE_REQ,
    output logic               ENABLE_FIR,
    output logic               COEFF_VALID,
    output logic [COEFF_W-1:0] COEFF_0,
    output logic [COEFF_W-1:0] COEFF_1,
    output logic [COEFF_W-1:0] COEFF_2,
    output logic [COEFF_W-1:0] COEFF_3,
    output logic [COEFF_W-1:0] COEFF_4,
    output logic [COEFF_W-1:0] COEFF_5,
    output logic [COEFF_W-1:0] COEFF_6,
    output logic [COEFF_W-1:0] COEFF_7,
    output logic               LOAD_BUSY,
    output logic               LOAD_DONE,
    output logic               LOAD_ERR
);

    loader_state_e      state_q;
    loader_state_e      state_d;
    logic [IDX_W-1:0]   index_q;
    logic [COEFF_W-1:0] shadow_q [NTAPS];
    logic [COEFF_W-1:0] active_q [NTAPS];
    logic               coeff_valid_q;
    logic               enable_fir_q;
    logic               load_done_q;
    logic               load_err_q;

    logic               accept;
    logic               load_word;
    logic               restart;
    logic               clear_burst;
    logic               cksum_err;

`ifdef FIR_COEFF_CKSUM_EN
    logic [COEFF_W-1:0] sum_q;
`endif

    assign WORD_READY = (state_q == LOAD)
`ifdef FIR_COEFF_CKSUM_EN
                      || (state_q == CHECK)
`endif
                      ;

    // A LOAD_START in the same cycle as a word wins: the word is dropped.
    assign accept      = WORD_VALID && WORD_READY && !LOAD_START;
    assign load_word   = accept && (state_q == LOAD);
    assign clear_burst = LOAD_START && (state_q != COMMIT);

    always_comb begin
        state_d   = state_q;
        restart   = 1'b0;
        cksum_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (LOAD_START) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (LOAD_START) begin
                    restart = 1'b1;
                    state_d = LOAD;
                end else if (accept && (index_q == IDX_W'(NTAPS - 1))) begin
`ifdef FIR_COEFF_CKSUM_EN
                    state_d = CHECK;
`else
                    state_d = COMMIT;
`endif
                end
            end
`ifdef FIR_COEFF_CKSUM_EN
            CHECK: begin
                if (LOAD_START) begin
                    restart = 1'b1;
                    state_d = LOAD;
                end else if (accept) begin
                    if (WORD_IN == sum_q) begin
                        state_d = COMMIT;
                    end else begin
                        cksum_err = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
`endif
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            index_q       <= '0;
            coeff_valid_q <= 1'b0;
            enable_fir_q  <= 1'b0;
            load_done_q   <= 1'b0;
            load_err_q    <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= (i == 0) ? UNITY_COEFF : '0;
            end
        end else begin
            state_q      <= state_d;
            load_done_q  <= (state_q == COMMIT);
            load_err_q   <= restart || cksum_err;
            enable_fir_q <= ENABLE_REQ && coeff_valid_q;

            if (clear_burst) begin
                index_q <= '0;
            end else if (load_word) begin
                shadow_q[index_q] <= WORD_IN;
                index_q           <= index_q + 1'b1;
            end

            // Whole-bank swap so the filter never sees a mix of old and new taps.
            if (state_q == COMMIT) begin
                for (int i = 0; i < NTAPS; i++) begin
                    active_q[i] <= shadow_q[i];
                end
                coeff_valid_q <= 1'b1;
            end
        end
    end

`ifdef FIR_COEFF_CKSUM_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sum_q <= '0;
        end else if (clear_burst) begin
            sum_q <= '0;
        end else if (load_word) begin
            sum_q <= sum_q + WORD_IN;
        end
    end
`endif

    assign COEFF_VALID = coeff_valid_q;
    assign ENABLE_FIR  = enable_fir_q;
    assign LOAD_DONE   = load_done_q;
    assign LOAD_ERR    = load_err_q;
    assign LOAD_BUSY   = (state_q != IDLE);

    assign COEFF_0 = active_q[0];
    assign COEFF_1 = active_q[1];
    assign COEFF_2 = active_q[2];
    assign COEFF_3 = active_q[3];
    assign COEFF_4 = active_q[4];
    assign COEFF_5 = active_q[5];
    assign COEFF_6 = active_q[6];
    assign COEFF_7 = active_q[7];

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Loads a set of eight 16-bit FIR coefficients from a slow configuration source over a valid/ready word stream and presents them, double-buffered, to the 8-tap FIR datapath. The block drives COEFF_0..COEFF_7 and ENABLE_FIR. The active coefficient set changes atomically in one clock, so the filter never sees a mix of old and new taps. It sits between the board configuration logic and the FIR instance in the same CLK domain.

## Interface
- COEFF_W, 16, coefficient width; coefficients are scaled by 2^13.
- UNITY_COEFF, 16'h2000, reset value of COEFF_0 (unity gain); COEFF_1..7 reset to 0.
- CLK  input  1  system clock; all logic is on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- LOAD_START  input  1  single-cycle pulse that begins a coefficient burst.
- WORD_IN  input  COEFF_W  stream word: a coefficient, or the checksum word when the checksum feature is built.
- WORD_VALID  input  1  WORD_IN is valid this cycle.
- WORD_READY  output  1  loader accepts WORD_IN this cycle.
- ENABLE_REQ  input  1  request from control to enable filtering.
- ENABLE_FIR  output  1  registered value of ENABLE_REQ & COEFF_VALID.
- COEFF_VALID  output  1  set by the first successful commit; cleared only by RESET.
- COEFF_0 .. COEFF_7  output  COEFF_W each  active coefficient bank.
- LOAD_BUSY  output  1  state is not IDLE.
- LOAD_DONE  output  1  one-cycle pulse when a commit completes.
- LOAD_ERR  output  1  one-cycle pulse on an aborted or rejected burst.

## Operation
- Storage: an 8-entry shadow bank written by the stream, and an active bank that drives the COEFF outputs.
- The FSM has states IDLE, LOAD, CHECK, COMMIT. CHECK exists only when the checksum feature is built.
- IDLE:
  - WORD_READY=0.
  - LOAD_START -> LOAD, with index=0 and sum=0.
- LOAD:
  - WORD_READY=1.
  - On WORD_VALID&WORD_READY: shadow[index]<=WORD_IN, sum<=sum+WORD_IN (mod 2^16), index++.
  - Acceptance at index==7 -> CHECK if the checksum feature is built, otherwise -> COMMIT.
- CHECK:
  - WORD_READY=1.
  - On an accepted word: if WORD_IN==sum -> COMMIT.
  - If WORD_IN!=sum -> IDLE with a LOAD_ERR pulse; the active bank is unchanged.
- COMMIT (one cycle):
  - WORD_READY=0.
  - At the end-of-cycle edge: active<=shadow (all 8 at once), COEFF_VALID<=1, LOAD_DONE<=1, -> IDLE.
- LOAD_START in LOAD or CHECK:
  - Pulses LOAD_ERR and restarts the burst (index=0, sum=0; stays in or returns to LOAD).
  - A word presented in that same cycle is discarded.
  - The active bank is untouched.
- LOAD_START in COMMIT is ignored; the host retries once LOAD_BUSY=0.
- LOAD_START in IDLE with WORD_VALID=1 in the same cycle: the word is not accepted (WORD_READY=0).
- A partial burst never reaches the active bank.
- ENABLE_FIR=0 whenever COEFF_VALID=0, regardless of ENABLE_REQ.

## Timing
- Reset values:
  - State IDLE; WORD_READY, LOAD_BUSY, LOAD_DONE, LOAD_ERR, COEFF_VALID and ENABLE_FIR all 0.
  - COEFF_0=UNITY_COEFF; COEFF_1..7=0.
  - index=0, sum=0.
- RESET mid-burst discards the shadow bank and returns every output to its reset value.
- Throughput: one word per cycle while WORD_VALID is held high.
- Commit latency: final handshake in cycle N -> COMMIT in cycle N+1 -> new COEFF values and LOAD_DONE=1 in cycle N+2.
- ENABLE_FIR follows ENABLE_REQ&COEFF_VALID with one cycle of latency. After the first commit, ENABLE_FIR can therefore first be 1 in cycle N+3.
- LOAD_ERR is high in the cycle after the offending LOAD_START or mismatching checksum word.
- All outputs are registered; WORD_READY is decoded from the state register only.

## Configuration
- FIR_COEFF_CKSUM_EN defined:
  - A 9th stream word is required, equal to the 16-bit wrap-around sum of the 8 coefficients.
  - CHECK state present; a mismatch pulses LOAD_ERR and nothing is committed.
- FIR_COEFF_CKSUM_EN undefined:
  - No CHECK state and no sum register.
  - COMMIT directly follows the 8th accepted word.
  - LOAD_ERR pulses only on a restart.

## Structure
- Shared package contents: NTAPS=8, COEFF_W=16, UNITY_COEFF, COEFF_FRAC_BITS=13, and the FSM state enum.
- Single module; the shadow and active banks are arrays indexed 0..7.
- No sub-module is required. The checksum accumulator is inline, under the macro.

## Test plan
- After RESET: COEFF_0=16'h2000, COEFF_1..7=0, COEFF_VALID=0, ENABLE_FIR=0 even with ENABLE_REQ=1.
- LOAD_START, then words 1..8 back-to-back (plus checksum 16'h0024 when built):
  - COEFF_k=k+1; LOAD_DONE pulses in cycle N+2.
  - ENABLE_FIR=1 in cycle N+3 with ENABLE_REQ=1.
- WORD_VALID toggling 1/0 during a burst: exactly 8 words (9 with checksum) are accepted; all COEFF outputs change in the same cycle.
- LOAD_START after 5 words: LOAD_ERR pulses, COEFF outputs are unchanged, and a following full burst commits correctly.
- With checksum built, sending 16'h0025 instead of 16'h0024: LOAD_ERR pulses, no LOAD_DONE, active bank unchanged.
- RESET asserted in LOAD after 3 words: all outputs return to their reset values and no commit occurs.
